// File: rtl/mem_access.sv
// mem_access: memory-access stage running a single-outstanding req/ack data-bus transaction,
// aligning/extending load data and registering the l3 writeback triple.
module mem_access #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] alu_q_l2,
    input  logic [31:0] alu_b_l2,
    input  logic [4:0]  rd_l2,
    input  logic        rd_wen_l2,
    input  logic        ins_lb_l2,
    input  logic        ins_lh_l2,
    input  logic        ins_lw_l2,
    input  logic        ins_lbu_l2,
    input  logic        ins_lhu_l2,
    input  logic        ins_sb_l2,
    input  logic        ins_sh_l2,
    input  logic        ins_sw_l2,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        stall,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        mem_err
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;
    state_t      r_state, w_state_nx;
    logic [15:0] r_cnt;
    logic        r_req, r_we, r_err, r_wb_en;
    logic [31:0] r_addr, r_wdata, r_wb_data;
    logic [3:0]  r_be;
    logic [4:0]  r_rd, r_wb_rd;
    logic        r_rd_wen, r_lb, r_lh, r_lbu, r_lhu, r_load;
    logic [1:0]  r_off;
    logic        w_load, w_store, w_mem, w_byte_op, w_half_op, w_mis, w_issue, w_tmo;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_ext;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    assign w_load    = ins_lb_l2 | ins_lh_l2 | ins_lw_l2 | ins_lbu_l2 | ins_lhu_l2;
    assign w_store   = ins_sb_l2 | ins_sh_l2 | ins_sw_l2;
    assign w_mem     = w_load | w_store;
    assign w_byte_op = ins_lb_l2 | ins_lbu_l2 | ins_sb_l2;
    assign w_half_op = ins_lh_l2 | ins_lhu_l2 | ins_sh_l2;
    assign w_mis     = (w_half_op & alu_q_l2[0]) | ((ins_lw_l2 | ins_sw_l2) & (alu_q_l2[1:0] != 2'b00));
    assign w_issue   = w_mem & ~w_mis;
    assign w_tmo     = r_cnt == 16'(TIMEOUT - 1);
    assign w_be      = w_byte_op ? 4'b0001 << alu_q_l2[1:0] :
                       w_half_op ? (alu_q_l2[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign w_wdata   = w_byte_op ? {4{alu_b_l2[7:0]}} : w_half_op ? {2{alu_b_l2[15:0]}} : alu_b_l2;
    assign w_byte    = bus_rdata[{r_off, 3'b000} +: 8];
    assign w_half    = bus_rdata[{r_off[1], 4'b0000} +: 16];
    assign w_ext     = r_lb  ? {{24{w_byte[7]}}, w_byte} :
                       r_lbu ? {24'b0, w_byte} :
                       r_lh  ? {{16{w_half[15]}}, w_half} :
                       r_lhu ? {16'b0, w_half} : bus_rdata;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nx;
    end
    // stall is gated by rst_n so it drops the moment reset is asserted, whatever l2 holds
    always_comb begin
        w_state_nx = r_state;
        stall      = 1'b0;
        if (r_state == S_IDLE) begin
            w_state_nx = w_issue ? S_WAIT : S_IDLE;
            stall      = rst_n & w_issue;
        end else begin
            w_state_nx = (bus_ack | w_tmo) ? S_IDLE : S_WAIT;
            stall      = rst_n & ~bus_ack;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_be      <= '0;
            r_wdata   <= '0;
            r_off     <= '0;
            r_rd      <= '0;
            r_rd_wen  <= 1'b0;
            r_lb      <= 1'b0;
            r_lh      <= 1'b0;
            r_lbu     <= 1'b0;
            r_lhu     <= 1'b0;
            r_load    <= 1'b0;
            r_err     <= 1'b0;
            r_wb_en   <= 1'b0;
            r_wb_rd   <= '0;
            r_wb_data <= '0;
        end else begin
            r_err <= 1'b0;
            if (r_state == S_IDLE) begin
                if (!w_mem) begin
                    r_wb_en   <= rd_wen_l2 & (rd_l2 != 5'd0);
                    r_wb_rd   <= rd_l2;
                    r_wb_data <= alu_q_l2;
                end else if (w_mis) begin
                    r_wb_en <= 1'b0;
                    r_err   <= 1'b1;
                end else begin
                    r_req    <= 1'b1;
                    r_we     <= w_store;
                    r_addr   <= {alu_q_l2[31:2], 2'b00};
                    r_be     <= w_be;
                    r_wdata  <= w_wdata;
                    r_off    <= alu_q_l2[1:0];
                    r_rd     <= rd_l2;
                    r_rd_wen <= rd_wen_l2;
                    r_lb     <= ins_lb_l2;
                    r_lh     <= ins_lh_l2;
                    r_lbu    <= ins_lbu_l2;
                    r_lhu    <= ins_lhu_l2;
                    r_load   <= w_load;
                    r_cnt    <= '0;
                    r_wb_en  <= 1'b0;
                end
            end else if (bus_ack) begin
                r_req     <= 1'b0;
                r_wb_en   <= r_load & r_rd_wen & (r_rd != 5'd0);
                r_wb_rd   <= r_rd;
                r_wb_data <= w_ext;
            end else begin
                r_wb_en <= 1'b0;
                r_cnt   <= r_cnt + 16'd1;
                if (w_tmo) begin
                    r_req <= 1'b0;
                    r_err <= 1'b1;
                end
            end
        end
    end
    assign bus_req   = r_req;
    assign bus_we    = r_we;
    assign bus_addr  = r_addr;
    assign bus_be    = r_be;
    assign bus_wdata = r_wdata;
    assign wb_en     = r_wb_en;
    assign wb_rd     = r_wb_rd;
    assign wb_data   = r_wb_data;
    assign mem_err   = r_err;
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: table-driven check of mem_access with TIMEOUT=4, plus timeout and mid-WAIT reset sequences.
module tb_mem_access;
    localparam logic [7:0] OP_LB = 8'h80, OP_LH = 8'h40, OP_LW = 8'h20, OP_LBU = 8'h10;
    localparam logic [7:0] OP_LHU = 8'h08, OP_SB = 8'h04, OP_SH = 8'h02, OP_SW = 8'h01, OP_ALU = 8'h00;
    logic        clk, rst_n;
    logic [31:0] alu_q_l2, alu_b_l2, bus_addr, bus_wdata, bus_rdata, wb_data;
    logic [4:0]  rd_l2, wb_rd;
    logic        rd_wen_l2, bus_req, bus_we, bus_ack, stall, wb_en, mem_err;
    logic [7:0]  op;
    logic [3:0]  bus_be;
    int          n_pass, n_total;
    mem_access #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .alu_q_l2(alu_q_l2), .alu_b_l2(alu_b_l2),
        .rd_l2(rd_l2), .rd_wen_l2(rd_wen_l2),
        .ins_lb_l2(op[7]), .ins_lh_l2(op[6]), .ins_lw_l2(op[5]), .ins_lbu_l2(op[4]),
        .ins_lhu_l2(op[3]), .ins_sb_l2(op[2]), .ins_sh_l2(op[1]), .ins_sw_l2(op[0]),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .stall(stall),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .mem_err(mem_err)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    typedef struct {
        logic [7:0]  op;
        logic [31:0] a, b;
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] rdata;
        int          dly;
        logic        bus, err;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we, wb_en;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
    } vec_t;
    vec_t vt[16];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask
    task automatic set_in(input logic [7:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic wen);
        op = o; alu_q_l2 = a; alu_b_l2 = b; rd_l2 = rd; rd_wen_l2 = wen;
    endtask
    task automatic do_op(input vec_t v, input int idx);
        int hi;
        set_in(v.op, v.a, v.b, v.rd, v.wen);
        #1;
        chk($sformatf("v%0d stall_issue", idx), {31'b0, stall}, {31'b0, v.bus});
        hi = stall ? 1 : 0;
        @(posedge clk); #1;
        if (v.bus) begin
            chk($sformatf("v%0d bus_req", idx), {31'b0, bus_req}, 32'd1);
            chk($sformatf("v%0d bus_addr", idx), bus_addr, v.addr);
            chk($sformatf("v%0d bus_be", idx), {28'b0, bus_be}, {28'b0, v.be});
            chk($sformatf("v%0d bus_we", idx), {31'b0, bus_we}, {31'b0, v.we});
            if (v.we) chk($sformatf("v%0d bus_wdata", idx), bus_wdata, v.wdata);
            for (int i = 0; i < v.dly; i++) begin
                if (stall) hi++;
                chk($sformatf("v%0d wait_req", idx), {31'b0, bus_req}, 32'd1);
                @(posedge clk); #1;
            end
            chk($sformatf("v%0d stall_cycles", idx), hi, v.dly + 1);
            bus_ack = 1'b1; bus_rdata = v.rdata;
            #1;
            chk($sformatf("v%0d stall_ack", idx), {31'b0, stall}, 32'd0);
            @(posedge clk); #1;
            bus_ack = 1'b0;
            set_in(OP_ALU, 32'h0, 32'h0, 5'd0, 1'b0);
            chk($sformatf("v%0d req_drop", idx), {31'b0, bus_req}, 32'd0);
        end else begin
            chk($sformatf("v%0d no_req", idx), {31'b0, bus_req}, 32'd0);
        end
        chk($sformatf("v%0d wb_en", idx), {31'b0, wb_en}, {31'b0, v.wb_en});
        chk($sformatf("v%0d mem_err", idx), {31'b0, mem_err}, {31'b0, v.err});
        if (v.wb_en) begin
            chk($sformatf("v%0d wb_rd", idx), {27'b0, wb_rd}, {27'b0, v.wb_rd});
            chk($sformatf("v%0d wb_data", idx), wb_data, v.wb_data);
        end
        if (v.err) begin
            set_in(OP_ALU, 32'h0, 32'h0, 5'd0, 1'b0);
            @(posedge clk); #1;
            chk($sformatf("v%0d err_pulse_end", idx), {31'b0, mem_err}, 32'd0);
        end
    endtask
    initial begin
        int hi;
        n_pass = 0; n_total = 0;
        vt[0]  = '{OP_SB,  32'h1003, 32'h000000AB, 5'd0,  1'b0, 32'h0,        3, 1'b1, 1'b0, 32'h1000, 4'b1000, 32'hABABABAB, 1'b1, 1'b0, 5'd0,  32'h0};
        vt[1]  = '{OP_LH,  32'h2002, 32'h0,        5'd5,  1'b1, 32'h80011234, 0, 1'b1, 1'b0, 32'h2000, 4'b1100, 32'h0,        1'b0, 1'b1, 5'd5,  32'hFFFF8001};
        vt[2]  = '{OP_LHU, 32'h2002, 32'h0,        5'd5,  1'b1, 32'h80011234, 0, 1'b1, 1'b0, 32'h2000, 4'b1100, 32'h0,        1'b0, 1'b1, 5'd5,  32'h00008001};
        vt[3]  = '{OP_LW,  32'h1001, 32'h0,        5'd6,  1'b1, 32'h0,        0, 1'b0, 1'b1, 32'h0,    4'b0000, 32'h0,        1'b0, 1'b0, 5'd0,  32'h0};
        vt[4]  = '{OP_ALU, 32'h55,   32'h0,        5'd3,  1'b1, 32'h0,        0, 1'b0, 1'b0, 32'h0,    4'b0000, 32'h0,        1'b0, 1'b1, 5'd3,  32'h55};
        vt[5]  = '{OP_ALU, 32'h55,   32'h0,        5'd0,  1'b1, 32'h0,        0, 1'b0, 1'b0, 32'h0,    4'b0000, 32'h0,        1'b0, 1'b0, 5'd0,  32'h0};
        vt[6]  = '{OP_LW,  32'h8,    32'h0,        5'd31, 1'b1, 32'hCAFEF00D, 2, 1'b1, 1'b0, 32'h8,    4'b1111, 32'h0,        1'b0, 1'b1, 5'd31, 32'hCAFEF00D};
        vt[7]  = '{OP_SW,  32'h4,    32'hDEADBEEF, 5'd7,  1'b1, 32'h0,        1, 1'b1, 1'b0, 32'h4,    4'b1111, 32'hDEADBEEF, 1'b1, 1'b0, 5'd0,  32'h0};
        vt[8]  = '{OP_SH,  32'h6,    32'h1234CAFE, 5'd0,  1'b0, 32'h0,        0, 1'b1, 1'b0, 32'h4,    4'b1100, 32'hCAFECAFE, 1'b1, 1'b0, 5'd0,  32'h0};
        vt[9]  = '{OP_LBU, 32'h101,  32'h0,        5'd9,  1'b1, 32'h11223344, 0, 1'b1, 1'b0, 32'h100,  4'b0010, 32'h0,        1'b0, 1'b1, 5'd9,  32'h33};
        vt[10] = '{OP_LH,  32'h11,   32'h0,        5'd4,  1'b1, 32'h0,        0, 1'b0, 1'b1, 32'h0,    4'b0000, 32'h0,        1'b0, 1'b0, 5'd0,  32'h0};
        vt[11] = '{OP_LW,  32'hC,    32'h0,        5'd10, 1'b0, 32'h1,        0, 1'b1, 1'b0, 32'hC,    4'b1111, 32'h0,        1'b0, 1'b0, 5'd0,  32'h0};
        vt[12] = '{OP_LB,  32'h2,    32'h0,        5'd12, 1'b1, 32'h00340000, 0, 1'b1, 1'b0, 32'h0,    4'b0100, 32'h0,        1'b0, 1'b1, 5'd12, 32'h34};
        vt[13] = '{OP_SH,  32'h3,    32'h5555,     5'd0,  1'b0, 32'h0,        0, 1'b0, 1'b1, 32'h0,    4'b0000, 32'h0,        1'b0, 1'b0, 5'd0,  32'h0};
        vt[14] = '{OP_SB,  32'h0,    32'h123456C3, 5'd0,  1'b0, 32'h0,        0, 1'b1, 1'b0, 32'h0,    4'b0001, 32'hC3C3C3C3, 1'b1, 1'b0, 5'd0,  32'h0};
        vt[15] = '{OP_LB,  32'h3,    32'h0,        5'd8,  1'b1, 32'h80AA55CC, 0, 1'b1, 1'b0, 32'h0,    4'b1000, 32'h0,        1'b0, 1'b1, 5'd8,  32'hFFFFFF80};
        rst_n = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
        set_in(OP_ALU, 32'h0, 32'h0, 5'd0, 1'b0);
        #3;
        chk("rst bus_req", {31'b0, bus_req}, 32'd0);
        chk("rst bus_addr", bus_addr, 32'h0);
        chk("rst bus_be_we", {27'b0, bus_be, bus_we}, 32'h0);
        chk("rst wb", {26'b0, wb_en, wb_rd}, 32'h0);
        chk("rst wb_data", wb_data, 32'h0);
        chk("rst err_stall", {30'b0, mem_err, stall}, 32'h0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 15; i++) do_op(vt[i], i);
        // timeout: no ack, bus_req must stay high exactly TIMEOUT cycles
        set_in(OP_LW, 32'h40, 32'h0, 5'd4, 1'b1);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (!bus_req) break;
            hi++;
            chk("tmo stall", {31'b0, stall}, 32'd1);
        end
        set_in(OP_ALU, 32'h0, 32'h0, 5'd0, 1'b0);
        chk("tmo req_cycles", hi, 32'd4);
        chk("tmo mem_err", {31'b0, mem_err}, 32'd1);
        chk("tmo wb_en", {31'b0, wb_en}, 32'd0);
        #1;
        chk("tmo idle_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        chk("tmo err_end", {31'b0, mem_err}, 32'd0);
        chk("tmo no_reissue", {31'b0, bus_req}, 32'd0);
        // bus_ack while idle is ignored
        bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
        #1;
        chk("idle_ack stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        bus_ack = 1'b0;
        chk("idle_ack req_wb", {30'b0, bus_req, wb_en}, 32'd0);
        // reset asserted mid-WAIT
        set_in(OP_LW, 32'h20, 32'h0, 5'd6, 1'b1);
        @(posedge clk); #1;
        chk("rstw issued", {31'b0, bus_req}, 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rstw bus_req", {31'b0, bus_req}, 32'd0);
        chk("rstw stall", {31'b0, stall}, 32'd0);
        chk("rstw wb_en", {31'b0, wb_en}, 32'd0);
        set_in(OP_ALU, 32'h0, 32'h0, 5'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus_ack = 1'b1; bus_rdata = 32'h12345678;
        #1;
        chk("rstw late_ack stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        bus_ack = 1'b0;
        chk("rstw late_ack", {30'b0, bus_req, wb_en}, 32'd0);
        do_op(vt[15], 15);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
